// File: rtl/pellet_renderer_multi_if.sv
// pellet_renderer_multi_if: game-logic control bus for the pellet renderer (eat, refill, status).
interface pellet_renderer_multi_if #(
  parameter int COLS = 28,
  parameter int ROWS = 31
);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int PLW = $clog2(COLS*ROWS+1);
  logic            eat;
  logic [CW-1:0]   eat_x;
  logic [RW-1:0]   eat_y;
  logic            refill;
  logic [RW-1:0]   refill_row;
  logic [COLS-1:0] refill_mask;
  logic            busy;
  logic [PLW-1:0]  pellets_left;
  logic            level_clear;
  modport master (
    output eat, eat_x, eat_y, refill, refill_mask,
    input  refill_row, busy, pellets_left, level_clear
  );
  modport slave (
    input  eat, eat_x, eat_y, refill, refill_mask,
    output refill_row, busy, pellets_left, level_clear
  );
endinterface

// File: rtl/pellet_renderer_multi.sv
// pellet_renderer_multi: maze pellet renderer with on-chip occupancy map, eat/refill control
// and power-pellet blink (blink built only when PELLET_BLINK_EN is defined).
`ifndef YELLOW
`define YELLOW 3'b110
`endif
`ifndef BLACK
`define BLACK 3'b000
`endif
module pellet_renderer_multi #(
  parameter int POS_W       = 10,
  parameter int TILE_SHIFT  = 4,
  parameter int COLS        = 28,
  parameter int ROWS        = 31,
  parameter int CELL_OFS    = 1,
  parameter int ACTIVE_W    = 480,
  parameter int ACTIVE_H    = 480,
  parameter int PWR_X0      = 2,
  parameter int PWR_X1      = 27,
  parameter int PWR_Y0      = 4,
  parameter int PWR_Y1      = 24,
  parameter int BLINK_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [POS_W-1:0]            shpos,
  input  logic [POS_W-1:0]            svpos,
  pellet_renderer_multi_if.slave      ctrl,
  output logic [2:0]                  color
);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int PLW = $clog2(COLS*ROWS+1);
  localparam int XW  = POS_W + 1;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t r_state, w_next;
  logic [COLS-1:0] r_map [ROWS];
  logic [RW-1:0]   r_row;
  logic [PLW-1:0]  r_left;
  logic            r_clear;
  logic [PLW-1:0]  w_pop;
  logic            w_eat;
  logic            w_last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  assign w_last = r_row == RW'(ROWS-1);
  always_comb begin
    w_next = r_state;
    w_next = ctrl.refill ? LOAD : (r_state == LOAD && w_last) ? IDLE : r_state;
  end
  always_comb begin
    w_pop = '0;
    for (int c = 0; c < COLS; c++) w_pop = w_pop + PLW'(ctrl.refill_mask[c]);
  end
  // Eats are only honoured while idle and only on a cell that still holds a pellet.
  assign w_eat = ctrl.eat && r_state == IDLE &&
                 {1'b0, ctrl.eat_x} < (CW+1)'(COLS) && {1'b0, ctrl.eat_y} < (RW+1)'(ROWS) &&
                 r_map[ctrl.eat_y][ctrl.eat_x];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) r_map[r] <= '0;
      r_row   <= '0;
      r_left  <= '0;
      r_clear <= 1'b0;
    end else if (ctrl.refill) begin
      r_row   <= '0;
      r_left  <= '0;
      r_clear <= 1'b0;
    end else if (r_state == LOAD) begin
      r_map[r_row] <= ctrl.refill_mask;
      r_left       <= r_left + w_pop;
      r_row        <= w_last ? '0 : r_row + 1'b1;
    end else if (w_eat) begin
      r_map[ctrl.eat_y][ctrl.eat_x] <= 1'b0;
      r_left  <= r_left - 1'b1;
      r_clear <= r_left == PLW'(1);
    end
  assign ctrl.refill_row   = r_row;
  assign ctrl.busy         = r_state == LOAD;
  assign ctrl.pellets_left = r_left;
  assign ctrl.level_clear  = r_clear;
  logic [XW-1:0] w_cx, w_cy;
  logic          w_vis, w_occ, w_pwr, w_hide, w_nrm, w_pin;
  logic          r_vis, r_occ, r_pwr;
  logic [2:0]    r_xo, r_yo;
  assign w_cx  = XW'(shpos >> TILE_SHIFT) + XW'(CELL_OFS);
  assign w_cy  = XW'(svpos >> TILE_SHIFT) + XW'(CELL_OFS);
  assign w_vis = {1'b0, shpos} < XW'(ACTIVE_W) && {1'b0, svpos} < XW'(ACTIVE_H) &&
                 w_cx < XW'(COLS) && w_cy < XW'(ROWS);
  // Read before any same-cycle eat lands, so the old bit is what gets rendered.
  assign w_occ = w_vis && r_map[w_cy[RW-1:0]][w_cx[CW-1:0]];
  assign w_pwr = (w_cx == XW'(PWR_X0) || w_cx == XW'(PWR_X1)) &&
                 (w_cy == XW'(PWR_Y0) || w_cy == XW'(PWR_Y1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_vis <= 1'b0;
      r_occ <= 1'b0;
      r_pwr <= 1'b0;
      r_xo  <= '0;
      r_yo  <= '0;
    end else begin
      r_vis <= w_vis;
      r_occ <= w_occ;
      r_pwr <= w_pwr;
      r_xo  <= shpos[TILE_SHIFT-1 -: 3];
      r_yo  <= svpos[TILE_SHIFT-1 -: 3];
    end
`ifdef PELLET_BLINK_EN
  logic                 r_fc, r_fc_d;
  logic [BLINK_SHIFT:0] r_frame;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_fc    <= 1'b0;
      r_fc_d  <= 1'b0;
      r_frame <= '0;
    end else begin
      r_fc    <= {1'b0, svpos} == XW'(ACTIVE_H);
      r_fc_d  <= r_fc;
      r_frame <= (r_fc && !r_fc_d) ? r_frame + 1'b1 : r_frame;
    end
  assign w_hide = r_frame[BLINK_SHIFT];
`else
  localparam logic [BLINK_SHIFT:0] FRAME0 = '0;
  assign w_hide = FRAME0[BLINK_SHIFT];
`endif
  assign w_nrm = (r_xo == 3'd3 || r_xo == 3'd4) && (r_yo == 3'd3 || r_yo == 3'd4);
  assign w_pin = r_xo >= 3'd2 && r_xo <= 3'd5 && r_yo >= 3'd2 && r_yo <= 3'd5 &&
                 !((r_xo == 3'd2 || r_xo == 3'd5) && (r_yo == 3'd2 || r_yo == 3'd5));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) color <= `BLACK;
    else          color <= (r_vis && r_occ && (r_pwr ? w_pin && !w_hide : w_nrm)) ? `YELLOW : `BLACK;
endmodule

// File: tb/tb_pellet_renderer_multi.sv
// tb_pellet_renderer_multi: scoreboard bench for pellet_renderer_multi (refill, eat, render, level clear, blink, reset).
`ifndef YELLOW
`define YELLOW 3'b110
`endif
`ifndef BLACK
`define BLACK 3'b000
`endif
module tb_pellet_renderer_multi;
  localparam int COLS = 28, ROWS = 31;
  localparam int CW = $clog2(COLS), RW = $clog2(ROWS);
`ifdef PELLET_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic [9:0] shpos = '0, svpos = '0;
  logic [2:0] color;
  logic t_vld = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [COLS-1:0] rm [ROWS];
  bit   m [ROWS][COLS];
  int   left = 0, frames = 0;
  bit   lc = 1'b0;
  logic [2:0] sbq[$];
  int   errors = 0, checks = 0;

  pellet_renderer_multi_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  pellet_renderer_multi dut (
    .clk(clk), .reset_n(reset_n), .shpos(shpos), .svpos(svpos), .ctrl(bus.slave), .color(color)
  );

  always #5 clk = ~clk;
  always_comb bus.refill_mask = rm[bus.refill_row];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model(input int x, input int y);
    int cx = (x >> 4) + 1, cy = (y >> 4) + 1, xo = (x >> 1) % 8, yo = (y >> 1) % 8;
    bit lit;
    if (x >= 480 || y >= 480 || cx >= COLS || cy >= ROWS) return `BLACK;
    if (!m[cy][cx]) return `BLACK;
    if ((cx == 2 || cx == 27) && (cy == 4 || cy == 24))
      lit = xo >= 2 && xo <= 5 && yo >= 2 && yo <= 5 && !((xo == 2 || xo == 5) && (yo == 2 || yo == 5)) &&
            !(BLINK && frames % 32 >= 16);
    else
      lit = (xo == 3 || xo == 4) && (yo == 3 || yo == 4);
    return lit ? `YELLOW : `BLACK;
  endfunction

  always @(posedge clk) begin
    v1 <= t_vld;
    v2 <= v1;
  end

  always @(negedge clk)
    if (v2) begin
      if (sbq.size() == 0) chk("sb_underflow", 1, 0);
      else chk("color", color, sbq.pop_front());
    end

  task automatic tick();
    @(negedge clk);
    t_vld = 1'b0; bus.eat = 1'b0; bus.refill = 1'b0; shpos = '0; svpos = '0;
  endtask

  task automatic pix(input int x, input int y);
    tick();
    shpos = 10'(x); svpos = 10'(y); t_vld = 1'b1;
    sbq.push_back(model(x, y));
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic frame();
    tick();
    svpos = 10'd480;
    tick();
    frames++;
  endtask

  task automatic eat_at(input int x, input int y);
    tick();
    bus.eat = 1'b1; bus.eat_x = CW'(x); bus.eat_y = RW'(y);
    if (x < COLS && y < ROWS && m[y][x]) begin
      m[y][x] = 1'b0;
      left--;
      if (left == 0) lc = 1'b1;
    end
    tick();
    chk("eat_left", bus.pellets_left, left);
    chk("eat_lclr", bus.level_clear, lc);
  endtask

  // eat_row >= 0 issues an ignored eat of (1,eat_row) while row 5 is loading.
  task automatic do_refill(input bit chk_rows, input int eat_row);
    tick();
    bus.refill = 1'b1;
    left = 0; lc = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      tick();
      if (chk_rows) begin
        chk("load_busy", bus.busy, 1);
        chk("load_row", bus.refill_row, r);
      end
      if (eat_row >= 0 && r == 5) begin
        bus.eat = 1'b1; bus.eat_x = CW'(1); bus.eat_y = RW'(eat_row);
      end
      for (int c = 0; c < COLS; c++) m[r][c] = rm[r][c];
      left += $countones(rm[r]);
    end
    tick();
    chk("refill_busy_end", bus.busy, 0);
    chk("refill_left", bus.pellets_left, left);
    chk("refill_lclr", bus.level_clear, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.eat = 1'b0; bus.eat_x = '0; bus.eat_y = '0; bus.refill = 1'b0;
    for (int r = 0; r < ROWS; r++) rm[r] = '1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_left", bus.pellets_left, 0);
    chk("rst_lclr", bus.level_clear, 0);
    chk("rst_row", bus.refill_row, 0);
    chk("rst_color", color, `BLACK);
    reset_n = 1'b1;
    pix(22, 54);
    drain();
    do_refill(1'b1, -1);
    pix(10'h40, 10'h66);
    pix(10'h46, 10'h66);
    pix(22, 54);
    pix(500, 54);
    pix(438, 54);
    pix(22, 490);
    drain();
    eat_at(5, 7);
    eat_at(5, 7);
    eat_at(30, 7);
    eat_at(3, 31);
    pix(10'h46, 10'h66);
    drain();
    // Same-cycle eat and render of cell (6,7): old bit shows, then it is gone.
    tick();
    bus.eat = 1'b1; bus.eat_x = CW'(6); bus.eat_y = RW'(7);
    shpos = 10'h56; svpos = 10'h66; t_vld = 1'b1;
    sbq.push_back(model(10'h56, 10'h66));
    m[7][6] = 1'b0; left--;
    pix(10'h56, 10'h66);
    drain();
    chk("same_cycle_left", bus.pellets_left, left);
    do_refill(1'b0, 0);
    pix(10'h56, 10'h66);
    drain();
    for (int r = 0; r < ROWS; r++) rm[r] = '0;
    rm[4][2] = 1'b1;
    do_refill(1'b0, -1);
    for (int f = 0; f < 34; f++) begin
      pix(22, 54);
      pix(10'h46, 10'h66);
      frame();
    end
    drain();
    eat_at(2, 4);
    for (int r = 0; r < ROWS; r++) rm[r] = '1;
    do_refill(1'b0, -1);
    tick();
    bus.refill = 1'b1;
    for (int r = 0; r <= 10; r++) tick();
    chk("mid_row", bus.refill_row, 10);
    reset_n = 1'b0;
    #1;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m[r][c] = 1'b0;
    left = 0; lc = 1'b0; frames = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_left", bus.pellets_left, 0);
    chk("abort_row", bus.refill_row, 0);
    chk("abort_color", color, `BLACK);
    @(negedge clk);
    reset_n = 1'b1;
    pix(10'h46, 10'h66);
    pix(22, 54);
    drain();
    chk("sb_remaining", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
